// File: rtl/spi_target.sv
// SPI mode-0 target: synchronises sck/csn/mosi into clk and exchanges bytes
// with firmware through a tx holding register and an rx data register.
//
// Ports:
//   clk, reset                   system clock, synchronous active-high reset
//   sck, csn, mosi               asynchronous SPI pins from the controller
//   miso, miso_oe                target data out and its pad output enable
//   tx_data, wr, busy            tx holding register load strobe and full flag
//   rx_data, valid, rd, overrun  received byte, unread flag, ack, sticky drop
//   selected                     synchronised, armed chip select
module spi_target #(
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       csn,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  input  logic       wr,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       valid,
  input  logic       rd,
  output logic       overrun,
  output logic       selected
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // Index 0 is s1, 1 is s2, 2 is s3.
  logic [2:0] sck_q;
  logic [2:0] csn_q;
  // mosi has no edge detector, so its s3 stage would drive nothing.
  logic [1:0] mosi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q  <= 3'b000;
      csn_q  <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      csn_q  <= {csn_q[1:0], csn};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  logic sck_rise, sck_fall, csn_rise, csn_fall;
  logic csn_s2, mosi_s2;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign csn_fall = ~csn_q[1] & csn_q[2];
  assign csn_s2   = csn_q[1];
  assign mosi_s2  = mosi_q[1];

  state_t     state, state_n;
  logic       armed, armed_n;
  logic [1:0] flush, flush_n;
  logic [2:0] bitcnt, bitcnt_n;
  logic [7:0] tx_sh, tx_n;
  logic [6:0] rx_sh, rx_sh_n;
  logic [7:0] hold, hold_n;
  logic       busy_n;
  logic [7:0] rx_data_n;
  logic       valid_n, overrun_n;
  logic       sel_n, oe_n;

  assign miso = tx_sh[7];

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      armed    <= 1'b0;
      flush    <= 2'd0;
      bitcnt   <= 3'd0;
      tx_sh    <= 8'hFF;
      rx_sh    <= 7'd0;
      hold     <= 8'd0;
      busy     <= 1'b0;
      rx_data  <= 8'd0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      selected <= 1'b0;
      miso_oe  <= 1'b0;
    end else begin
      state    <= state_n;
      armed    <= armed_n;
      flush    <= flush_n;
      bitcnt   <= bitcnt_n;
      tx_sh    <= tx_n;
      rx_sh    <= rx_sh_n;
      hold     <= hold_n;
      busy     <= busy_n;
      rx_data  <= rx_data_n;
      valid    <= valid_n;
      overrun  <= overrun_n;
      selected <= sel_n;
      miso_oe  <= oe_n;
    end
  end

  always_comb begin
    state_n   = state;
    armed_n   = armed;
    flush_n   = flush;
    bitcnt_n  = bitcnt;
    tx_n      = tx_sh;
    rx_sh_n   = rx_sh;
    hold_n    = hold;
    busy_n    = busy;
    rx_data_n = rx_data;
    valid_n   = valid;
    overrun_n = overrun;
    sel_n     = selected;
    oe_n      = miso_oe;

    // The csn synchroniser resets to 1, so arming waits until s2
    // holds a real pin sample; otherwise a frame live across reset
    // would look like a fresh select.
    if (flush != 2'd2)
      flush_n = flush + 2'd1;
    else if (csn_s2)
      armed_n = 1'b1;

    if (rd) begin
      valid_n   = 1'b0;
      overrun_n = 1'b0;
    end

    case (state)
      IDLE: begin
        if (csn_fall && armed) begin
          state_n  = SHIFT;
          bitcnt_n = 3'd0;
          tx_n     = busy ? hold : FILL;
          busy_n   = 1'b0;
          sel_n    = 1'b1;
          oe_n     = 1'b1;
        end
      end
      SHIFT: begin
        if (csn_rise) begin
          state_n  = IDLE;
          bitcnt_n = 3'd0;
          tx_n     = 8'hFF;
          sel_n    = 1'b0;
          oe_n     = 1'b0;
        end else if (sck_rise) begin
          rx_sh_n  = {rx_sh[5:0], mosi_s2};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) begin
            if (!valid || rd) begin
              rx_data_n = {rx_sh, mosi_s2};
              valid_n   = 1'b1;
            end else begin
              overrun_n = 1'b1;
            end
          end
        end else if (sck_fall) begin
          if (bitcnt != 3'd0) begin
            tx_n = {tx_sh[6:0], 1'b1};
          end else begin
            tx_n   = busy ? hold : FILL;
            busy_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // A reload only clears busy when it was set, so a wr landing
    // on a FILL reload still latches and leaves busy high.
    if (wr && !busy) begin
      hold_n = tx_data;
      busy_n = 1'b1;
    end
  end

endmodule
